// File: rtl/giga_mc_cu_if.sv
// Control-unit bundle: IR fields and memory handshake in, datapath/regfile/FPU strobes out.
interface giga_mc_cu_if;
    logic [5:0] opcode;
    logic [4:0] fmt;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       fp_reg_write;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       link;
    logic       fp_start;
    logic [1:0] fp_control;
    logic       illegal;
    logic [2:0] state;

    modport master (
        input  opcode, fmt, mem_ready,
        output pc_write, ir_write, mem_read, mem_write, reg_write, fp_reg_write,
               alu_op, alu_src, reg_dst, mem_to_reg, branch, jump, link,
               fp_start, fp_control, illegal, state
    );

    modport slave (
        output opcode, fmt, mem_ready,
        input  pc_write, ir_write, mem_read, mem_write, reg_write, fp_reg_write,
               alu_op, alu_src, reg_dst, mem_to_reg, branch, jump, link,
               fp_start, fp_control, illegal, state
    );
endinterface

// File: rtl/giga_mc_cu.sv
// Multi-cycle control FSM for the mini-MIPS core: FETCH/DECODE/EXEC/MEM/WB plus a
// fixed-latency FPEXEC phase for COP1 arithmetic.
module giga_mc_cu #(
    parameter int FP_LAT = 4,
    parameter int CNT_W  = 4
) (
    input  logic clk,
    input  logic rst,
    giga_mc_cu_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FPEXEC = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_RTYPE, C_LW, C_SW, C_IADD, C_IOR, C_BRANCH, C_MFC1, C_MTC1, C_FPAR
    } cls_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       fp_reg_write;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       link;
        logic       fp_start;
        logic [1:0] fp_control;
        logic       illegal;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_COP1  = 6'b010001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [4:0] FMT_MFC1 = 5'b00000;
    localparam logic [4:0] FMT_MTC1 = 5'b00100;
    localparam logic [4:0] FMT_S    = 5'b10000;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FP_LAT - 1);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d, dec_cls;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dec_j, dec_jal;
    ctl_t             ctl, ctl_g;

    // Instruction classification; only consumed while in DECODE.
    always_comb begin
        dec_cls = C_NONE;
        dec_j   = 1'b0;
        dec_jal = 1'b0;
        case (bus.opcode)
            OP_RTYPE:                  dec_cls = C_RTYPE;
            OP_LW:                     dec_cls = C_LW;
            OP_SW:                     dec_cls = C_SW;
            OP_ADDI, OP_ADDIU, OP_LUI: dec_cls = C_IADD;
            OP_ORI:                    dec_cls = C_IOR;
            OP_BEQ, OP_BNE:            dec_cls = C_BRANCH;
            OP_J:                      dec_j   = 1'b1;
            OP_JAL:                    dec_jal = 1'b1;
            OP_COP1: begin
                case (bus.fmt)
                    FMT_MFC1: dec_cls = C_MFC1;
                    FMT_MTC1: dec_cls = C_MTC1;
                    FMT_S:    dec_cls = C_FPAR;
                    default:  dec_cls = C_NONE;
                endcase
            end
            default: dec_cls = C_NONE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; reset here is synchronous, checked inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal written below gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        ctl     = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_j || dec_jal) begin
                    ctl.jump      = 1'b1;
                    ctl.link      = dec_jal;
                    ctl.reg_write = dec_jal;
                    state_d       = S_FETCH;
                end else begin
                    case (dec_cls)
                        C_NONE: begin
                            ctl.illegal = 1'b1;
                            state_d     = S_FETCH;
                        end
                        C_MFC1, C_MTC1: state_d = S_WB;
                        C_FPAR: begin
                            ctl.fp_start = 1'b1;
                            cnt_d        = CNT_LOAD;
                            state_d      = S_FPEXEC;
                        end
                        default: state_d = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                case (cls_q)
                    C_RTYPE: begin
                        ctl.alu_op  = 2'b10;
                        ctl.reg_dst = 1'b1;
                    end
                    C_LW, C_SW: begin
                        ctl.alu_src = 1'b1;
                        state_d     = S_MEM;
                    end
                    C_IADD: ctl.alu_src = 1'b1;
                    C_IOR: begin
                        ctl.alu_op  = 2'b11;
                        ctl.alu_src = 1'b1;
                    end
                    C_BRANCH: begin
                        ctl.alu_op = 2'b01;
                        ctl.branch = 1'b1;
                        state_d    = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                ctl.mem_read  = (cls_q == C_LW);
                ctl.mem_write = (cls_q == C_SW);
                if (cls_q != C_LW && cls_q != C_SW) begin
                    state_d = S_FETCH;
                end else if (bus.mem_ready) begin
                    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                case (cls_q)
                    C_RTYPE: begin
                        ctl.reg_write = 1'b1;
                        ctl.reg_dst   = 1'b1;
                    end
                    C_IADD, C_IOR: begin
                        ctl.reg_write = 1'b1;
                        ctl.alu_src   = 1'b1;
                    end
                    C_LW: begin
                        ctl.reg_write  = 1'b1;
                        ctl.mem_to_reg = 1'b1;
                    end
                    C_MFC1: begin
                        ctl.reg_write  = 1'b1;
                        ctl.fp_control = 2'b01;
                    end
                    C_MTC1: begin
                        ctl.fp_reg_write = 1'b1;
                        ctl.fp_control   = 2'b10;
                    end
                    C_FPAR: begin
                        ctl.fp_reg_write = 1'b1;
                        ctl.fp_control   = 2'b11;
                    end
                    default: ctl = '0;
                endcase
            end
            S_FPEXEC: begin
                ctl.fp_control = 2'b11;
                if (cnt_q == '0) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset suppresses every strobe in the same cycle, so a pending write never escapes.
    assign ctl_g = rst ? '0 : ctl;

    assign bus.pc_write     = ctl_g.pc_write;
    assign bus.ir_write     = ctl_g.ir_write;
    assign bus.mem_read     = ctl_g.mem_read;
    assign bus.mem_write    = ctl_g.mem_write;
    assign bus.reg_write    = ctl_g.reg_write;
    assign bus.fp_reg_write = ctl_g.fp_reg_write;
    assign bus.alu_op       = ctl_g.alu_op;
    assign bus.alu_src      = ctl_g.alu_src;
    assign bus.reg_dst      = ctl_g.reg_dst;
    assign bus.mem_to_reg   = ctl_g.mem_to_reg;
    assign bus.branch       = ctl_g.branch;
    assign bus.jump         = ctl_g.jump;
    assign bus.link         = ctl_g.link;
    assign bus.fp_start     = ctl_g.fp_start;
    assign bus.fp_control   = ctl_g.fp_control;
    assign bus.illegal      = ctl_g.illegal;
    assign bus.state        = rst ? 3'd0 : state_q;
endmodule

// File: tb/tb_giga_mc_cu.sv
// Scoreboard bench for giga_mc_cu: per-instruction cycle recipes feed an expected-output
// queue; a negedge monitor compares two instances (FP_LAT=4 and FP_LAT=1).
module tb_giga_mc_cu;
    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    typedef enum int {
        P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_FPEXEC
    } phase_e;

    typedef enum int {
        K_R, K_LW, K_SW, K_ADDI, K_ADDIU, K_LUI, K_ORI, K_BEQ, K_BNE,
        K_J, K_JAL, K_MFC1, K_MTC1, K_FPAR, K_ILL_OP, K_ILL_FMT
    } kind_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       fp_reg_write;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       link;
        logic       fp_start;
        logic [1:0] fp_control;
        logic       illegal;
        logic [2:0] state;
    } outv_t;

    typedef struct {
        outv_t exp;
        bit    sel;
        int    cyc;
        string tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    bit   sel = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    giga_mc_cu_if bus_a();
    giga_mc_cu_if bus_b();

    giga_mc_cu #(.FP_LAT(LAT_A), .CNT_W(4)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a.master));
    giga_mc_cu #(.FP_LAT(LAT_B), .CNT_W(4)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b.master));

    always #5 clk = ~clk;

    outv_t act_a, act_b;
    assign act_a = {bus_a.pc_write, bus_a.ir_write, bus_a.mem_read, bus_a.mem_write,
                    bus_a.reg_write, bus_a.fp_reg_write, bus_a.alu_op, bus_a.alu_src,
                    bus_a.reg_dst, bus_a.mem_to_reg, bus_a.branch, bus_a.jump, bus_a.link,
                    bus_a.fp_start, bus_a.fp_control, bus_a.illegal, bus_a.state};
    assign act_b = {bus_b.pc_write, bus_b.ir_write, bus_b.mem_read, bus_b.mem_write,
                    bus_b.reg_write, bus_b.fp_reg_write, bus_b.alu_op, bus_b.alu_src,
                    bus_b.reg_dst, bus_b.mem_to_reg, bus_b.branch, bus_b.jump, bus_b.link,
                    bus_b.fp_start, bus_b.fp_control, bus_b.illegal, bus_b.state};

    // Expected outputs for one cycle of an instruction, straight from the per-phase rules.
    function automatic outv_t model_out(input phase_e ph, input kind_e k, input logic rdy);
        outv_t o = '0;
        case (ph)
            P_FETCH: begin
                o.state    = 3'd0;
                o.mem_read = 1'b1;
                o.pc_write = rdy;
                o.ir_write = rdy;
            end
            P_DECODE: begin
                o.state = 3'd1;
                if (k == K_J) o.jump = 1'b1;
                if (k == K_JAL) begin
                    o.jump = 1'b1; o.link = 1'b1; o.reg_write = 1'b1;
                end
                if (k == K_FPAR) o.fp_start = 1'b1;
                if (k == K_ILL_OP || k == K_ILL_FMT) o.illegal = 1'b1;
            end
            P_EXEC: begin
                o.state = 3'd2;
                case (k)
                    K_R: begin o.alu_op = 2'b10; o.reg_dst = 1'b1; end
                    K_ORI: begin o.alu_op = 2'b11; o.alu_src = 1'b1; end
                    K_BEQ, K_BNE: begin o.alu_op = 2'b01; o.branch = 1'b1; end
                    default: o.alu_src = 1'b1;
                endcase
            end
            P_MEM: begin
                o.state     = 3'd3;
                o.mem_read  = (k == K_LW);
                o.mem_write = (k == K_SW);
            end
            P_WB: begin
                o.state = 3'd4;
                case (k)
                    K_R: begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
                    K_LW: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
                    K_MFC1: begin o.reg_write = 1'b1; o.fp_control = 2'b01; end
                    K_MTC1: begin o.fp_reg_write = 1'b1; o.fp_control = 2'b10; end
                    K_FPAR: begin o.fp_reg_write = 1'b1; o.fp_control = 2'b11; end
                    default: begin o.reg_write = 1'b1; o.alu_src = 1'b1; end
                endcase
            end
            P_FPEXEC: begin
                o.state      = 3'd5;
                o.fp_control = 2'b11;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic encode(input kind_e k, output logic [5:0] op, output logic [4:0] fm);
        logic [5:0] bad_ops [8] = '{6'b111111, 6'b000001, 6'b000110, 6'b001010,
                                    6'b100000, 6'b101000, 6'b010000, 6'b010010};
        fm = 5'($urandom);
        case (k)
            K_R:     op = 6'b000000;
            K_LW:    op = 6'b100011;
            K_SW:    op = 6'b101011;
            K_ADDI:  op = 6'b001000;
            K_ADDIU: op = 6'b001001;
            K_LUI:   op = 6'b001111;
            K_ORI:   op = 6'b001101;
            K_BEQ:   op = 6'b000100;
            K_BNE:   op = 6'b000101;
            K_J:     op = 6'b000010;
            K_JAL:   op = 6'b000011;
            K_MFC1:  begin op = 6'b010001; fm = 5'b00000; end
            K_MTC1:  begin op = 6'b010001; fm = 5'b00100; end
            K_FPAR:  begin op = 6'b010001; fm = 5'b10000; end
            K_ILL_OP: op = bad_ops[$urandom_range(0, 7)];
            default: begin
                op = 6'b010001;
                while (fm == 5'b00000 || fm == 5'b00100 || fm == 5'b10000) fm = 5'($urandom);
            end
        endcase
    endtask

    task automatic drive_cycle(input bit r, input logic [5:0] op, input logic [4:0] fm,
                               input logic rdy, input outv_t exp, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_a = sel ? 1'b1 : r;
        rst_b = sel ? r : 1'b1;
        bus_a.opcode = op; bus_b.opcode = op;
        bus_a.fmt = fm;    bus_b.fmt = fm;
        bus_a.mem_ready = rdy; bus_b.mem_ready = rdy;
        e.exp = exp; e.sel = sel; e.cyc = cyc; e.tag = tag;
        sb.push_back(e);
        cyc++;
    endtask

    // One instruction: build its cycle recipe, then drive it; rst_at >= 0 aborts with reset.
    task automatic run_instr(input kind_e k, input int fw, input int mw, input int rst_at);
        phase_e     ph_q[$];
        logic       rdy_q[$];
        logic [5:0] op;
        logic [4:0] fm;
        int         lat = sel ? LAT_B : LAT_A;
        encode(k, op, fm);
        for (int i = 0; i < fw; i++) begin ph_q.push_back(P_FETCH); rdy_q.push_back(1'b0); end
        ph_q.push_back(P_FETCH);  rdy_q.push_back(1'b1);
        ph_q.push_back(P_DECODE); rdy_q.push_back(1'($urandom));
        case (k)
            K_R, K_ADDI, K_ADDIU, K_LUI, K_ORI: begin
                ph_q.push_back(P_EXEC); rdy_q.push_back(1'($urandom));
                ph_q.push_back(P_WB);   rdy_q.push_back(1'($urandom));
            end
            K_LW, K_SW: begin
                ph_q.push_back(P_EXEC); rdy_q.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin ph_q.push_back(P_MEM); rdy_q.push_back(1'b0); end
                ph_q.push_back(P_MEM); rdy_q.push_back(1'b1);
                if (k == K_LW) begin ph_q.push_back(P_WB); rdy_q.push_back(1'($urandom)); end
            end
            K_BEQ, K_BNE: begin ph_q.push_back(P_EXEC); rdy_q.push_back(1'($urandom)); end
            K_MFC1, K_MTC1: begin ph_q.push_back(P_WB); rdy_q.push_back(1'($urandom)); end
            K_FPAR: begin
                for (int i = 0; i < lat; i++) begin ph_q.push_back(P_FPEXEC); rdy_q.push_back(1'($urandom)); end
                ph_q.push_back(P_WB); rdy_q.push_back(1'($urandom));
            end
            default: ;
        endcase
        for (int i = 0; i < ph_q.size(); i++) begin
            if (i == rst_at) begin
                drive_cycle(1'b1, 6'($urandom), 5'($urandom), 1'($urandom), '0,
                            {k.name(), "/reset"});
                return;
            end
            if (ph_q[i] == P_DECODE)
                drive_cycle(1'b0, op, fm, rdy_q[i], model_out(ph_q[i], k, rdy_q[i]),
                            {k.name(), "/", ph_q[i].name()});
            else
                drive_cycle(1'b0, 6'($urandom), 5'($urandom), rdy_q[i],
                            model_out(ph_q[i], k, rdy_q[i]), {k.name(), "/", ph_q[i].name()});
        end
    endtask

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            kind_e k = kind_e'($urandom_range(0, 15));
            int    ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
            run_instr(k, $urandom_range(0, 2), $urandom_range(0, 3), ra);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares it with the selected instance.
    initial begin
        exp_t  e;
        outv_t act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = e.sel ? act_b : act_a;
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL cyc%0d dut%0d %s: outputs got %h want %h",
                             e.cyc, e.sel, e.tag, act, e.exp);
                end
                n_checks++;
                if ((act.pc_write && act.reg_write) || (act.mem_read && act.mem_write)) begin
                    n_fail++;
                    $display("FAIL cyc%0d dut%0d %s exclusive: got %h want no pc/reg or rd/wr overlap",
                             e.cyc, e.sel, e.tag, act);
                end
            end
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.opcode = '0; bus_a.fmt = '0; bus_a.mem_ready = 1'b0;
        bus_b.opcode = '0; bus_b.fmt = '0; bus_b.mem_ready = 1'b0;

        sel = 1'b0;
        drive_cycle(1'b1, 6'h23, 5'h0, 1'b1, '0, "reset");
        drive_cycle(1'b1, 6'h23, 5'h0, 1'b1, '0, "reset");
        run_instr(K_LW, 2, 3, -1);
        run_instr(K_R, 0, 0, -1);
        run_instr(K_FPAR, 0, 0, -1);
        run_instr(K_MTC1, 0, 0, -1);
        run_instr(K_MFC1, 0, 0, -1);
        run_instr(K_ILL_OP, 0, 0, -1);
        run_instr(K_ILL_FMT, 1, 0, -1);
        run_instr(K_JAL, 0, 0, -1);
        run_instr(K_FPAR, 0, 0, 3);
        run_instr(K_R, 0, 0, -1);
        run_instr(K_SW, 0, 3, 4);
        run_instr(K_SW, 0, 1, -1);
        random_run(150);

        sel = 1'b1;
        drive_cycle(1'b1, 6'h11, 5'h10, 1'b1, '0, "reset");
        run_instr(K_FPAR, 0, 0, -1);
        run_instr(K_FPAR, 1, 0, 2);
        run_instr(K_ORI, 0, 0, -1);
        random_run(150);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/giga_mc_cu.md
Name: giga_mc_cu

Overview:
- Multi-cycle control FSM for the mini-MIPS core. It supersedes the single-cycle combinational opcode decoder.
- Sequences FETCH, DECODE, EXEC, MEM, WB and FPEXEC per instruction.
- Inserts memory wait states through a ready handshake.
- Runs a parametrised-latency floating-point execute phase for COP1 arithmetic, and handles MFC1/MTC1 moves.
- Sits between instruction memory/IR and the datapath muxes, register files and FP unit.

Parameters:
- FP_LAT, 4, cycles spent in FPEXEC for COP1 arithmetic; legal range 1..15.
- CNT_W, 4, width of the FP latency counter; must satisfy 2^CNT_W > FP_LAT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  6  IR[31:26], sampled in DECODE
- fmt  in  5  IR[25:21] (COP1 sub-op: 00000 MFC1, 00100 MTC1, 10000 FP arith single)
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC <= PC+4 strobe
- ir_write  out  1  IR load strobe
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  GPR write enable
- fp_reg_write  out  1  FPR write enable
- alu_op  out  2  00 add, 01 sub/compare, 10 R-type funct, 11 or
- alu_src  out  1  1 = immediate
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = memory data to GPR
- branch  out  1  branch-resolve strobe (beq/bne)
- jump  out  1  jump strobe
- link  out  1  jal: write PC+4 to $31
- fp_start  out  1  one-cycle FP unit start pulse
- fp_control  out  2  00 none, 01 MFC1, 10 MTC1, 11 FP arith
- illegal  out  1  one-cycle pulse on unsupported opcode/fmt
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FPEXEC=5

Behaviour:
- Reset: while rst=1, state<=FETCH, the latched class and counter clear, and every output is 0. This includes mem_read, which is gated by rst.
- Outputs: a combinational function of the registered state and the instruction class latched in DECODE. No output glitches on opcode changes outside DECODE.
- FETCH:
  - mem_read=1 every cycle.
  - Stay while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
- DECODE (1 cycle): latch opcode/fmt into class, then:
  - R-type, lw, sw, addi, addiu, lui, ori, beq, bne -> EXEC.
  - j -> jump=1, FETCH.
  - jal -> jump=1, link=1, reg_write=1, FETCH.
  - COP1 with fmt MFC1/MTC1 -> WB.
  - COP1 with fmt FP arith -> FPEXEC, with fp_start=1 in this DECODE cycle and the counter loaded with FP_LAT-1.
  - Any other opcode, or COP1 with other fmt -> illegal=1, FETCH, no write/memory strobe.
- EXEC (1 cycle), driven with the same alu_op/alu_src/reg_dst values as the single-cycle decode:
  - R-type -> WB.
  - lw/sw -> MEM.
  - addi/addiu/lui/ori -> WB.
  - beq/bne -> branch=1, FETCH.
- MEM:
  - lw: mem_read=1. sw: mem_write=1.
  - Stay while mem_ready=0.
  - On mem_ready=1: lw -> WB; sw -> FETCH.
  - Request stays asserted and stable through wait states.
- WB (1 cycle), then FETCH:
  - R-type: reg_write=1, reg_dst=1.
  - I-type ALU: reg_write=1, reg_dst=0, alu_src=1.
  - lw: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MFC1: reg_write=1, fp_control=01.
  - MTC1: fp_reg_write=1, fp_control=10.
  - FP arith: fp_reg_write=1, fp_control=11.
- FPEXEC:
  - fp_control=11.
  - Counter decrements each cycle; exit to WB when the counter is 0.
  - Occupancy is exactly FP_LAT cycles. FP_LAT=1 gives a single FPEXEC cycle.
- Cycle counts with mem_ready=1 throughout:
  - j/jal: 2
  - beq/bne, MFC1/MTC1: 3
  - R-type, I-type ALU, sw: 4
  - lw: 5
  - FP arith: 3+FP_LAT
- Exclusivity: pc_write never coincides with reg_write. mem_read and mem_write are never both 1.
- Reset mid-instruction (any state, including MEM wait or FPEXEC): next state is FETCH. No pending write or strobe is issued after rst.
- Unused state encodings 6 and 7 return to FETCH on the next cycle with all outputs 0.

Test Plan:
- Reset then lw, opcode=100011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEM:
  - state sequence 0,0,0,1,2,3,3,3,3,4,0.
  - mem_read held through the waits; reg_write=1 and mem_to_reg=1 only in WB.
- R-type add, opcode=000000, mem_ready=1:
  - 4 cycles; alu_op=10 in EXEC; reg_write=1 and reg_dst=1 only in WB; next state FETCH.
- FP arith, opcode=010001, fmt=10000, FP_LAT=4:
  - fp_start pulses once in DECODE; 4 FPEXEC cycles; then fp_reg_write=1 and fp_control=11 for one cycle; 7 cycles total.
  - Repeat with FP_LAT=1: 4 cycles total.
- MTC1 (fmt=00100) then MFC1 (fmt=00000):
  - 3 cycles each.
  - MTC1: fp_reg_write=1 with fp_control=10, reg_write=0.
  - MFC1: reg_write=1 with fp_control=01, fp_reg_write=0.
- Illegal cases, opcode=111111 and COP1 fmt=00001:
  - illegal=1 for one cycle in DECODE; no reg_write, fp_reg_write, mem_write or pc_write beyond the FETCH strobe; back to FETCH.
- Reset mid-operation:
  - rst=1 during the second FPEXEC cycle: next cycle state=0 and all outputs 0; fp_reg_write never asserted.
  - rst=1 during sw MEM wait: mem_write drops the same cycle and is not re-issued.
